// File: rtl/bus_arbiter_if.sv
// 68000 bus-arbitration signal bundle shared between the CPU pins, DMA requesters
// and bus_arbiter. The master modport is the arbiter side.
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic               as_n;
    logic               bg_n;
    logic               br_n;
    logic               bgack_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               preempt;
    logic               busy;

    modport master (
        input  as_n, bg_n, req,
        output br_n, bgack_n, gnt, preempt, busy
    );

    modport slave (
        output as_n, bg_n, req,
        input  br_n, bgack_n, gnt, preempt, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin DMA bus-mastership controller driving the 68000 BR/BG/BGACK handshake,
// with bounded tenure (preempt) and an enforced CPU gap between tenures.
module bus_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned MAX_TENURE = 64,
    parameter int unsigned CPU_GAP    = 4
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.master bus
);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_IDLE,
        OWNED,
        RELEASE,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic               br_n_q, br_n_d;
    logic               bgack_n_q, bgack_n_d;
    logic               preempt_q, preempt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [TW-1:0]      ten_q, ten_d;
    logic [7:0]         gap_q, gap_d;

    logic [PW-1:0]      win_idx;
    logic               win_found;
    int unsigned        cand;
    logic               req_any;

    assign req_any = |bus.req;

    // First asserted request searching upward from the slot after the last winner.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!win_found && bus.req[PW'(cand)]) begin
                win_idx   = PW'(cand);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            preempt_q <= 1'b0;
            gnt_q     <= '0;
            ptr_q     <= PW'(NUM_REQ - 1);
            ten_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            br_n_q    <= br_n_d;
            bgack_n_q <= bgack_n_d;
            preempt_q <= preempt_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            ten_q     <= ten_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        br_n_d    = br_n_q;
        bgack_n_d = bgack_n_q;
        preempt_d = preempt_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        ten_d     = ten_q;
        gap_d     = gap_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = REQUEST;
                    br_n_d  = 1'b0;
                end
            end
            REQUEST: begin
                if (!bus.bg_n) begin
                    state_d = WAIT_IDLE;
                end else if (!req_any) begin
                    state_d = GAP;
                    br_n_d  = 1'b1;
                    gap_d   = '0;
                end
            end
            WAIT_IDLE: begin
                // A withdrawn request wins over a simultaneous AS release.
                if (!req_any) begin
                    state_d = GAP;
                    br_n_d  = 1'b1;
                    gap_d   = '0;
                end else if (bus.as_n) begin
                    state_d        = OWNED;
                    bgack_n_d      = 1'b0;
                    br_n_d         = 1'b1;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = win_idx;
                    ten_d          = '0;
                end
            end
            OWNED: begin
                if (!bus.req[ptr_q]) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    bgack_n_d = 1'b1;
                    preempt_d = 1'b0;
                end else begin
                    if (ten_q != TW'(MAX_TENURE)) begin
                        ten_d = ten_q + TW'(1);
                    end
                    if ((MAX_TENURE != 0) && (ten_d == TW'(MAX_TENURE))) begin
                        preempt_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                // Exits after max(CPU_GAP,1) cycles in GAP.
                if (({1'b0, gap_q} + 9'd1) >= 9'(CPU_GAP)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.br_n    = br_n_q;
    assign bus.bgack_n = bgack_n_q;
    assign bus.gnt     = gnt_q;
    assign bus.preempt = preempt_q;
    assign bus.busy    = (state_q != IDLE);
endmodule
